smi_read_streamer: RTL and testbench

Sequencer on the accelerator side of the shared memory interface read port. It turns one job descriptor (base address, stride, word count) into a burst of strided shared-memory reads. Words arrive through the address-register and valid-flag handshake of the shared memory interface and are buffered in a small FIFO. The FIFO drives a ready/valid word stream toward the HD encoder datapath.

---
 rtl/smi_read_streamer.sv | 154 +++++++++++++++
 tb/tb_smi_read_streamer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_read_streamer.sv
// Turns one descriptor (base, stride, count) into a run of strided shared-memory reads.
// The words are buffered in a small FIFO and presented as a ready/valid stream.
module smi_read_streamer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int ADDR_WIDTH   = 32,
    parameter int STRIDE_WIDTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [STRIDE_WIDTH-1:0] stride_i,
    input  logic [CNT_WIDTH-1:0]    count_i,
    input  logic                    abort_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DATA_WIDTH-1:0]   stream_data_o,
    output logic                    stream_valid_o,
    output logic                    stream_last_o,
    input  logic                    stream_ready_i,
    output logic                    smi_raddr_we_o,
    output logic [ADDR_WIDTH-1:0]   smi_raddr_o,
    output logic                    smi_raddr_stride_we_o,
    output logic [STRIDE_WIDTH-1:0] smi_raddr_stride_o,
    output logic                    smi_raddr_inc_o,
    input  logic [DATA_WIDTH-1:0]   smi_read_data_i,
    input  logic                    smi_read_data_valid_i,
    output logic                    smi_clear_o,
    output logic [1:0]              dbg_state_o
);
    // Stream handshake: a word moves when stream_valid_o && stream_ready_i on a rising
    // edge; valid never depends on ready, and the head word is stable while valid && !ready.
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FETCH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [STRIDE_WIDTH-1:0] r_stride;
    logic [CNT_WIDTH-1:0]    r_remaining;
    logic                    r_done;
    logic                    r_clear;
    logic [DATA_WIDTH:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W:0]          r_count;

    logic w_full, w_empty, w_abort, w_accept, w_push, w_pop, w_last_word, w_drain_done;
    logic w_we, w_inc;

    assign w_full       = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_abort      = abort_i && (r_state != S_IDLE);
    assign w_accept     = start_i && !abort_i && (r_state == S_IDLE);
    assign w_push       = (r_state == S_FETCH) && smi_read_data_valid_i && !w_full && !abort_i;
    assign w_pop        = !w_empty && stream_ready_i;
    assign w_last_word  = (r_remaining == CNT_WIDTH'(1));
    // The final pop ends the job in the same cycle, so done_o lands one cycle later.
    assign w_drain_done = (r_state == S_DRAIN) && !abort_i &&
                          (w_empty || ((r_count == (PTR_W+1)'(1)) && w_pop));

    always_comb begin
        w_next = r_state;
        w_we   = 1'b0;
        w_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (count_i != '0)) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_we   = 1'b1;
                w_next = S_FETCH;
            end
            S_FETCH: begin
                if (w_push) begin
                    if (w_last_word) w_next = S_DRAIN;
                    else             w_inc  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_drain_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
            w_we   = 1'b0;
            w_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_stride    <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_clear     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_accept && (count_i == '0)) || w_drain_done;
            r_clear <= w_abort;
            if (w_accept && (count_i != '0)) begin
                r_addr      <= base_addr_i;
                r_stride    <= stride_i;
                r_remaining <= count_i;
            end else if (w_abort) begin
                r_remaining <= '0;
            end else if (w_push) begin
                r_remaining <= r_remaining - CNT_WIDTH'(1);
            end
            if (w_abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
                else if (!w_push && w_pop) r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

    // Storage needs no reset: the head word is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_last_word, smi_read_data_i};
    end

    assign busy_o                = (r_state != S_IDLE);
    assign done_o                = r_done;
    assign stream_valid_o        = !w_empty;
    assign stream_data_o         = w_empty ? '0 : r_mem[r_rd_ptr][DATA_WIDTH-1:0];
    assign stream_last_o         = w_empty ? 1'b0 : r_mem[r_rd_ptr][DATA_WIDTH];
    assign smi_raddr_we_o        = w_we;
    assign smi_raddr_stride_we_o = w_we;
    assign smi_raddr_o           = r_addr;
    assign smi_raddr_stride_o    = r_stride;
    assign smi_raddr_inc_o       = w_inc;
    assign smi_clear_o           = r_clear;
    assign dbg_state_o           = r_state;
endmodule

// File: tb/tb_smi_read_streamer.sv
// Directed bench for smi_read_streamer with a 2-cycle-latency memory model (data = address).
module tb_smi_read_streamer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [31:0] stride = '0;
    logic [15:0] count = '0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic        busy, done, s_valid, s_last, we, stride_we, inc, clr;
    logic [31:0] s_data, raddr, rstride, rd_data;
    logic        rd_valid;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    smi_read_streamer dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .stride_i(stride),
        .count_i(count), .abort_i(abort), .busy_o(busy), .done_o(done),
        .stream_data_o(s_data), .stream_valid_o(s_valid), .stream_last_o(s_last),
        .stream_ready_i(ready), .smi_raddr_we_o(we), .smi_raddr_o(raddr),
        .smi_raddr_stride_we_o(stride_we), .smi_raddr_stride_o(rstride),
        .smi_raddr_inc_o(inc), .smi_read_data_i(rd_data),
        .smi_read_data_valid_i(rd_valid), .smi_clear_o(clr), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory model: any address write or increment invalidates, data appears 2 cycles later.
    logic [31:0] m_addr = '0;
    logic [31:0] m_stride = '0;
    logic [1:0]  m_lat = '0;
    logic        m_valid = 1'b0;
    always @(posedge clk) begin
        if (rst || clr) begin
            m_valid <= 1'b0;
            m_lat   <= '0;
        end else if (we) begin
            m_addr   <= raddr;
            m_stride <= rstride;
            m_valid  <= 1'b0;
            m_lat    <= 2'd2;
        end else if (inc) begin
            m_addr  <= m_addr + m_stride;
            m_valid <= 1'b0;
            m_lat   <= 2'd2;
        end else if (m_lat != 2'd0) begin
            m_lat <= m_lat - 2'd1;
            if (m_lat == 2'd1) m_valid <= 1'b1;
        end
    end
    assign rd_data  = m_addr;
    assign rd_valid = m_valid;

    // Observation counters and the received-word log.
    int we_cnt = 0, inc_cnt = 0, done_cnt = 0, clr_cnt = 0, pop_cnt = 0;
    logic [32:0] rx_q[$];
    always @(posedge clk) begin
        if (!rst) begin
            if (we)   we_cnt++;
            if (inc)  inc_cnt++;
            if (done) done_cnt++;
            if (clr)  clr_cnt++;
            if (s_valid && ready) begin
                pop_cnt++;
                rx_q.push_back({s_last, s_data});
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] b, input logic [31:0] s, input logic [15:0] c);
        @(negedge clk);
        start = 1'b1; base = b; stride = s; count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int snap;
        snap = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != snap) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_inc(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (inc_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int s_we, s_inc, s_done, s_clr, s_pop, rx0, n;
        logic [31:0] exp_q[$];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", s_valid, 0);
        check("rst_data", s_data, 0);
        check("rst_raddr", raddr, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;

        // Basic job: base 0x100, stride 4, count 3
        ready = 1'b1;
        s_we = we_cnt; s_inc = inc_cnt; s_done = done_cnt; rx0 = rx_q.size();
        start_job(32'h100, 32'h4, 16'd3);
        check("basic_busy_t1", busy, 1);
        check("basic_we", {we, stride_we}, 2'b11);
        check("basic_raddr", raddr, 32'h100);
        check("basic_stride", rstride, 32'h4);
        wait_done(100, ok);
        check("basic_done_seen", ok, 1);
        check("basic_busy_at_done", busy, 0);
        repeat (3) @(negedge clk);
        check("basic_we_cnt", we_cnt - s_we, 1);
        check("basic_inc_cnt", inc_cnt - s_inc, 2);
        check("basic_done_cnt", done_cnt - s_done, 1);
        check("basic_rx_len", rx_q.size() - rx0, 3);
        exp_q = '{32'h100, 32'h104, 32'h108};
        for (int i = 0; i < 3; i++)
            if (rx0 + i < rx_q.size())
                check($sformatf("basic_word%0d", i), rx_q[rx0 + i], {(i == 2), exp_q[i]});

        // Zero count
        s_we = we_cnt; s_inc = inc_cnt;
        start_job(32'h500, 32'h4, 16'd0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        @(negedge clk);
        check("zero_done_pulse", done, 0);
        check("zero_busy2", busy, 0);
        check("zero_strobes", {32'(we_cnt - s_we), 32'(inc_cnt - s_inc)}, 64'd0);

        // Backpressure: count 6 into a 4-entry FIFO with ready low
        ready = 1'b0;
        s_inc = inc_cnt; s_pop = pop_cnt; rx0 = rx_q.size();
        start_job(32'h1000, 32'h10, 16'd6);
        wait_inc(s_inc + 4, 200, ok);
        check("bp_four_pushes", ok, 1);
        repeat (8) @(negedge clk);
        check("bp_held_inc", inc_cnt - s_inc, 4);
        check("bp_no_pop", pop_cnt - s_pop, 0);
        check("bp_head", {s_valid, s_data}, {1'b1, 32'h1000});
        check("bp_held_data", rd_data, 32'h1040);
        ready = 1'b1;
        wait_done(200, ok);
        check("bp_done_seen", ok, 1);
        check("bp_inc_total", inc_cnt - s_inc, 5);
        check("bp_rx_len", rx_q.size() - rx0, 6);
        for (int i = 0; i < 6; i++)
            if (rx0 + i < rx_q.size())
                check($sformatf("bp_word%0d", i), rx_q[rx0 + i], {(i == 5), 32'h1000 + 32'(i) * 32'h10});

        // Abort at the 2nd push of a count-8 job
        s_done = done_cnt; s_clr = clr_cnt;
        start_job(32'h2000, 32'h4, 16'd8);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (inc) n++;
            if (n == 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_reach_push2", ok, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_clear", clr, 1);
        check("abort_valid", s_valid, 0);
        check("abort_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("abort_clr_cnt", clr_cnt - s_clr, 1);
        check("abort_no_done", done_cnt - s_done, 0);
        s_inc = inc_cnt; rx0 = rx_q.size();
        start_job(32'h200, 32'h8, 16'd2);
        wait_done(100, ok);
        check("post_abort_done", ok, 1);
        check("post_abort_inc", inc_cnt - s_inc, 1);
        check("post_abort_rx_len", rx_q.size() - rx0, 2);
        if (rx_q.size() >= rx0 + 2) begin
            check("post_abort_w0", rx_q[rx0], {1'b0, 32'h200});
            check("post_abort_w1", rx_q[rx0 + 1], {1'b1, 32'h208});
        end

        // Start while busy is ignored
        s_we = we_cnt; s_inc = inc_cnt; s_done = done_cnt; rx0 = rx_q.size();
        start_job(32'h300, 32'h4, 16'd3);
        wait_inc(s_inc + 1, 100, ok);
        check("busy_in_fetch", ok, 1);
        start_job(32'h900, 32'h10, 16'd5);
        wait_done(100, ok);
        check("busy_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        check("busy_we_cnt", we_cnt - s_we, 1);
        check("busy_done_cnt", done_cnt - s_done, 1);
        check("busy_rx_len", rx_q.size() - rx0, 3);
        for (int i = 0; i < 3; i++)
            if (rx0 + i < rx_q.size())
                check($sformatf("busy_word%0d", i), rx_q[rx0 + i], {(i == 2), 32'h300 + 32'(i) * 32'h4});

        // Reset mid-job with 2 words buffered
        ready = 1'b0;
        s_inc = inc_cnt;
        start_job(32'h400, 32'h4, 16'd4);
        wait_inc(s_inc + 2, 100, ok);
        check("rstmid_two_pushes", ok, 1);
        check("rstmid_head", {s_valid, s_data}, {1'b1, 32'h400});
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_outs", {busy, done, s_valid, s_last, we, stride_we, inc, clr}, 8'd0);
        check("rstmid_data", s_data, 0);
        check("rstmid_regs", {raddr, rstride}, 64'd0);
        check("rstmid_state", dbg_state, 0);
        rst = 1'b0;
        ready = 1'b1;
        s_pop = pop_cnt;
        repeat (5) @(negedge clk);
        check("rstmid_empty", s_valid, 0);
        check("rstmid_no_pop", pop_cnt - s_pop, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
